// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple dual-port byte-enable RAM.
// Lane helpers take lanes zero-extended to LMAX bits; callers cast back.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } seq_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int LMAX    = 64;

  // Even parity of one lane (zero padding does not change it)
  function automatic logic lane_parity(
    input logic [LMAX-1:0] v
  );
    return ^v;
  endfunction

  // One lane of a write merge: enabled lanes take the new value
  function automatic logic [LMAX-1:0] lane_merge(
    input logic [LMAX-1:0] old_v,
    input logic [LMAX-1:0] new_v,
    input logic            be
  );
    return be ? new_v : old_v;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then holds READY.
// Drives the shared write port while clearing.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  output logic                 clr_we,
  output logic [ADDR_SIZE-1:0] clr_addr
);

  seq_state_e           state;
  seq_state_e           state_n;
  logic [ADDR_SIZE-1:0] addr;

  // State register and clear address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      addr  <= '0;
    end else begin
      state <= state_n;
      if (clr_we) addr <= addr + ADDR_SIZE'(1);
    end
  end

  // Next state and outputs; last address write ends the sequence
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    clr_we  = 1'b0;
    unique case (1'b1)
      (state == CLEAR): begin
        clr_we = 1'b1;
        if (addr == '1) state_n = READY;
      end
      (state == READY): ready = 1'b1;
      default: ;
    endcase
  end

  assign clr_addr = addr;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with lane enables, RDW mode, optional out register.
// Define RAM_SDP_PARITY_EN for per-lane even parity and rd_parity_err.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE = 11,
  parameter int DATA_SIZE = 18,
  parameter int LANE_SIZE = 9,
  parameter int RDW_MODE  = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           ready,
  input  logic                           wr_en,
  input  logic [ADDR_SIZE-1:0]           wr_addr,
  input  logic [DATA_SIZE/LANE_SIZE-1:0] wr_be,
  input  logic [DATA_SIZE-1:0]           wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_SIZE-1:0]           rd_addr,
  output logic [DATA_SIZE-1:0]           rd_data,
  output logic                           rd_valid
`ifdef RAM_SDP_PARITY_EN
  ,
  output logic [DATA_SIZE/LANE_SIZE-1:0] rd_parity_err
`endif
);

  localparam int LANES = DATA_SIZE / LANE_SIZE;
  localparam int L     = LANE_SIZE;
`ifdef RAM_SDP_PARITY_EN
  localparam int PB    = 1;
`else
  localparam int PB    = 0;
`endif
  localparam int LW    = L + PB;
  localparam int MW    = LANES * LW;
  localparam int DEPTH = 1 << ADDR_SIZE;

  if (DATA_SIZE % LANE_SIZE != 0) begin : g_bad_lane
    $error("DATA_SIZE must be a multiple of LANE_SIZE");
  end
  if (LANE_SIZE > LMAX) begin : g_bad_lmax
    $error("LANE_SIZE exceeds LMAX");
  end

  logic [MW-1:0]        mem [DEPTH];

  logic                 clr_we;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 we;
  logic                 uwe;
  logic                 ren;
  logic                 byp;
  logic [ADDR_SIZE-1:0] waddr;
  logic [LANES-1:0]     wbe;
  logic [MW-1:0]        wword;

  logic                 v1;
  logic [MW-1:0]        rq;
  logic [LANES-1:0]     bbe;
  logic [DATA_SIZE-1:0] bdat;
  logic [DATA_SIZE-1:0] d1;
`ifdef RAM_SDP_PARITY_EN
  logic [LANES-1:0]     e1;
`endif

  ram_clear_seq #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign uwe   = ready & wr_en;
  assign ren   = ready & rd_en;
  assign we    = clr_we | uwe;
  assign waddr = clr_we ? clr_addr : wr_addr;
  assign wbe   = clr_we ? '1 : wr_be;
  assign byp   = (RDW_MODE == RDW_NEW) && uwe
               && (wr_addr == rd_addr);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [L-1:0] wd;
    logic [L-1:0] od;
    assign wd = clr_we ? '0 : wr_data[i*L +: L];
    assign od = rq[i*LW +: L];
`ifdef RAM_SDP_PARITY_EN
    assign wword[i*LW +: LW] = {lane_parity(LMAX'(wd)), wd};
    assign e1[i] = !bbe[i]
                 && (lane_parity(LMAX'(od)) != rq[i*LW+L]);
`else
    assign wword[i*LW +: LW] = wd;
`endif
    assign d1[i*L +: L] = L'(lane_merge(LMAX'(od),
                                        LMAX'(bdat[i*L +: L]),
                                        bbe[i]));
  end

  // Storage write port: per-lane enables, shared by clear and user
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && wbe[i]) mem[waddr][i*LW +: LW] <= wword[i*LW +: LW];
    end
  end

  // Read stage: registered word plus bypass lanes for RDW new-data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      rq   <= '0;
      bbe  <= '0;
      bdat <= '0;
    end else begin
      v1 <= ren;
      if (ren) begin
        rq   <= mem[rd_addr];
        bbe  <= byp ? wr_be : '0;
        bdat <= wr_data;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    // Output register: data held until the next valid result
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= v1;
        if (v1) rd_data <= d1;
      end
    end
`ifdef RAM_SDP_PARITY_EN
    // Parity flags pulse with rd_valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_parity_err <= '0;
      else        rd_parity_err <= v1 ? e1 : '0;
    end
`endif
  end else begin : g_nreg
    assign rd_valid = v1;
    assign rd_data  = d1;
`ifdef RAM_SDP_PARITY_EN
    assign rd_parity_err = e1 & {LANES{v1}};
`endif
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (old-data/latency 1, new-data/latency 2)
// checked against a word-array model with lane masks.
module tb_ram_sdp_be;

  localparam int AS    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [1:0]  wr_be = '0;
  logic [17:0] wr_data = '0;

  logic        r0, r1, v0, v1;
  logic [17:0] d0, d1;
`ifdef RAM_SDP_PARITY_EN
  logic [1:0]  pe0, pe1;
`endif

  int vecs = 0;
  int errs = 0;

  logic [17:0] m_mem [DEPTH];
  logic        m_ready;
  int          clr_n;
  logic        e0_v, e1_v, p_v;
  logic [17:0] e0_d, e1_d, p_d;

  always #5 clk = ~clk;

  ram_sdp_be #(
    .ADDR_SIZE (AS), .DATA_SIZE (18), .LANE_SIZE (9),
    .RDW_MODE  (0),  .OUT_REG   (0)
  ) u0 (
    .clk (clk), .rst_n (rst_n), .ready (r0),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_be (wr_be),
    .wr_data (wr_data), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (d0), .rd_valid (v0)
`ifdef RAM_SDP_PARITY_EN
    , .rd_parity_err (pe0)
`endif
  );

  ram_sdp_be #(
    .ADDR_SIZE (AS), .DATA_SIZE (18), .LANE_SIZE (9),
    .RDW_MODE  (1),  .OUT_REG   (1)
  ) u1 (
    .clk (clk), .rst_n (rst_n), .ready (r1),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_be (wr_be),
    .wr_data (wr_data), .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (d1), .rd_valid (v1)
`ifdef RAM_SDP_PARITY_EN
    , .rd_parity_err (pe1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("ready_u0", 32'(r0), 32'(m_ready));
    chk("ready_u1", 32'(r1), 32'(m_ready));
    chk("valid_u0", 32'(v0), 32'(e0_v));
    chk("valid_u1", 32'(v1), 32'(e1_v));
    chk("data_u0",  32'(d0), 32'(e0_d));
    chk("data_u1",  32'(d1), 32'(e1_d));
  endtask

  // One clock edge: model computes what the edge should do, then compare
  task automatic tick();
    logic [17:0] mask, old_w, new_w;
    logic        rf, wf;
    rf    = m_ready && rd_en;
    wf    = m_ready && wr_en;
    mask  = {(wr_be[1] ? 9'h1FF : 9'h000), (wr_be[0] ? 9'h1FF : 9'h000)};
    old_w = m_mem[rd_addr];
    new_w = (wf && wr_addr == rd_addr)
          ? ((old_w & ~mask) | (wr_data & mask)) : old_w;
    @(posedge clk);
    #1;
    if (wf) m_mem[wr_addr] = (m_mem[wr_addr] & ~mask) | (wr_data & mask);
    if (!m_ready) begin
      clr_n++;
      if (clr_n == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
    e0_v = rf;
    if (rf) e0_d = old_w;
    e1_v = p_v;
    if (p_v) e1_d = p_d;
    p_v = rf;
    p_d = new_w;
    chk_all();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    clr_n   = 0;
    e0_v = 1'b0; e1_v = 1'b0; p_v = 1'b0;
    e0_d = '0;   e1_d = '0;   p_d = '0;
    #2;
    chk_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [17:0] d,
                        input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic set_rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset, then strobes during a partial clear are ignored
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_wr(4'(i), 18'h3FFFF, 2'b11);
      set_rd(4'(i));
      tick();
    end

    // Mid-clear reset: clear restarts, ready after 16 edges
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(4'(i + 3), 18'($urandom), 2'b11);
      set_rd(4'(i));
      tick();
      chk("ready_edge", 32'(r0), 32'(i == DEPTH - 1));
    end
    idle();

    // All addresses read back zero
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(4'(i));
      tick();
    end
    idle();
    tick();
    tick();

    // Byte enables
    set_wr(4'd5, 18'h3FFFF, 2'b11); tick();
    set_wr(4'd5, 18'h00000, 2'b01); tick();
    idle();
    set_rd(4'd5); tick();
    chk("be_u0", 32'(d0), 32'h3FE00);
    idle(); tick();
    chk("be_u1", 32'(d1), 32'h3FE00);

    // Same-address read-during-write
    set_wr(4'd3, 18'h00155, 2'b11); tick();
    set_wr(4'd3, 18'h2AAAA, 2'b11);
    set_rd(4'd3); tick();
    chk("rdw_old", 32'(d0), 32'h00155);
    idle(); tick();
    chk("rdw_new", 32'(d1), 32'h2AAAA);

    // Streaming reads then hold
    set_wr(4'd0, 18'h11111, 2'b11); tick();
    set_wr(4'd1, 18'h22222, 2'b11); tick();
    set_wr(4'd2, 18'h33333, 2'b11); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      set_rd(4'(i));
      tick();
    end
    idle();
    tick();
    tick();
    chk("hold_u1", 32'(d1), 32'h33333);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      wr_en   = 1'($urandom);
      rd_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      wr_be   = 2'($urandom);
      wr_data = 18'($urandom);
      tick();
    end
    idle();
    tick();
    tick();

`ifdef RAM_SDP_PARITY_EN
    // Corrupt a stored lane-1 data bit at address 9
    u0.mem[9][10] = ~u0.mem[9][10];
    u1.mem[9][10] = ~u1.mem[9][10];
    m_mem[9] = m_mem[9] ^ 18'h00200;
    set_rd(4'd9); tick();
    chk("par_u0", 32'(pe0), 32'h2);
    chk("par_u1_early", 32'(pe1), 32'h0);
    set_rd(4'd4); tick();
    chk("par_u0_clean", 32'(pe0), 32'h0);
    chk("par_u1", 32'(pe1), 32'h2);
    idle(); tick();
    chk("par_u1_clean", 32'(pe1), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
